store_merge_unit: RTL and testbench

//  Store-side counterpart of the load extract path: executes SB/SH/SW into a word-wide data memory that has no byte enables.
//  SW is a direct write. SB/SH do read-modify-write: read word, merge byte/half lane, write back.

---
 rtl/store_merge_unit.sv | 164 ++++++++++++++++
 tb/tb_store_merge_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// store_merge_unit
//   Executes SB/SH/SW into a word-wide data memory that has no byte enables.
//   SW writes the whole word directly. SB/SH read the word, replace the
//   addressed byte/half lane and write the word back. Little-endian.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   req_valid/ready    store request handshake; ready only while idle
//   inst/addr/wdata    store instruction, byte address, rs2 data (sampled at accept)
//   mem_addr           word-aligned address during READ/WAIT/WRITE, else 0
//   mem_re/mem_rdata   read strobe; read data is valid the cycle after mem_re
//   mem_we/mem_wdata   one-cycle write strobe and full merged word
//   done/fault         one-cycle completion / rejection pulses

// One byte lane of the read-modify-write merge.
module store_merge_lane (
    input  logic       sel,
    input  logic [7:0] new_byte,
    input  logic [7:0] old_byte,
    output logic [7:0] merged
);
    assign merged = sel ? new_byte : old_byte;
endmodule

module store_merge_unit #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [WIDTH-1:0]      inst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  mem_we,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  done,
    output logic                  fault
);
    localparam int         NUM_LANES = WIDTH / 8;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [2:0] F3_SB     = 3'b000;
    localparam logic [2:0] F3_SH     = 3'b001;
    localparam logic [2:0] F3_SW     = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE, S_FAULT
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           wdata_q;     // only the SB/SH payload is needed after accept
    logic [2:0]            funct3_q;
    logic [WIDTH-1:0]      merge_q;
    logic [WIDTH-1:0]      lane_merged;

    // Request decode, only meaningful while idle.
    logic [2:0] req_f3;
    logic       req_bad;
    logic       accept;

    assign req_f3  = inst[14:12];
    assign accept  = req_valid && (state == S_IDLE);
    assign req_bad = (inst[6:0] != OP_STORE)
                  || !(req_f3 == F3_SB || req_f3 == F3_SH || req_f3 == F3_SW)
                  || (req_f3 == F3_SH && addr[0])
                  || (req_f3 == F3_SW && addr[1:0] != 2'b00);

    // Instruction bits outside opcode/funct3 do not matter to a store merge.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst[WIDTH-1:15], inst[11:7]};

    // Per-lane merge of latched store data into the word read from memory.
    // SB selects one byte by addr[1:0]; SH selects the half by addr[1] and
    // feeds the low/high payload byte to the even/odd lane of that half.
    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            localparam logic [1:0] LANE = 2'(g);
            localparam int         HLO  = (g % 2) * 8;
            logic       sel;
            logic [7:0] new_byte;
            assign sel      = (funct3_q == F3_SB) ? (addr_q[1:0] == LANE)
                                                  : (addr_q[1] == LANE[1]);
            assign new_byte = (funct3_q == F3_SB) ? wdata_q[7:0] : wdata_q[HLO +: 8];
            store_merge_lane u_lane (
                .sel      (sel),
                .new_byte (new_byte),
                .old_byte (mem_rdata[8*g +: 8]),
                .merged   (lane_merged[8*g +: 8])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            merge_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q   <= addr;
                wdata_q  <= wdata[15:0];
                funct3_q <= req_f3;
                if (req_f3 == F3_SW) merge_q <= wdata;
            end else if (state == S_WAIT) begin
                merge_q <= lane_merged;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
        fault     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad)               state_nxt = S_FAULT;
                    else if (req_f3 == F3_SW)  state_nxt = S_WRITE;
                    else                       state_nxt = S_READ;
                end
            end
            S_READ: begin
                mem_re    = 1'b1;
                mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata = merge_q;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_FAULT: begin
                fault     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] inst, addr, wdata;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        done, fault;

    int n_cmp  = 0;
    int n_fail = 0;

    store_merge_unit #(.WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .inst(inst), .addr(addr), .wdata(wdata), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    // Phase codes describing what the outputs must look like in one cycle.
    localparam int P_IDLE = 0, P_READ = 1, P_WAIT = 2, P_WRITE = 3, P_DONE = 4, P_FAULT = 5;

    typedef struct {
        string       name;
        logic [31:0] inst, addr, wdata, rdata;
        logic        fault;
        logic [31:0] merged;
    } vec_t;

    function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3);
        logic [31:0] r;
        r = 32'h00A5_0000;
        r[14:12] = f3;
        r[6:0] = opc;
        return r;
    endfunction

    function automatic logic [68:0] outs();
        return {req_ready, mem_re, mem_we, done, fault, mem_addr, mem_wdata};
    endfunction

    function automatic logic [68:0] exp_of(input int p, input logic [31:0] al, input logic [31:0] m);
        case (p)
            P_IDLE:  return {5'b10000, 32'h0, 32'h0};
            P_READ:  return {5'b01000, al, 32'h0};
            P_WAIT:  return {5'b00000, al, 32'h0};
            P_WRITE: return {5'b00100, al, m};
            P_DONE:  return {5'b00010, 32'h0, 32'h0};
            default: return {5'b00001, 32'h0, 32'h0};
        endcase
    endfunction

    task automatic check(input string nm, input logic [68:0] act, input logic [68:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {rdy,re,we,done,fault,addr,wdata}=%h expected %h", nm, act, exp);
        end
    endtask

    // Reference: byte-array view of the word, store rules applied directly.
    function automatic logic [32:0] model(input logic [31:0] i, a, wd, rd);
        logic [7:0] b [4];
        logic [2:0] f3;
        logic       flt;
        logic [31:0] m;
        int base;
        f3  = i[14:12];
        flt = (i[6:0] != 7'h23) || (f3 > 3'd2) || (f3 == 3'd1 && a[0]) ||
              (f3 == 3'd2 && (a % 4) != 0);
        for (int k = 0; k < 4; k++) b[k] = rd[8*k +: 8];
        if (f3 == 3'd0) b[a % 4] = wd[7:0];
        if (f3 == 3'd1) begin
            base = int'(a % 4) & 2;
            b[base] = wd[7:0];
            b[base + 1] = wd[15:8];
        end
        m = {b[3], b[2], b[1], b[0]};
        if (f3 == 3'd2) m = wd;
        return {flt, m};
    endfunction

    // One complete transaction, checked cycle by cycle from accept to idle.
    task automatic do_store(input string nm, input logic [31:0] i_inst, i_addr, i_wdata, i_rdata,
                            input logic e_fault, input logic [31:0] e_merged);
        int ph[$];
        logic [31:0] al;
        al = {i_addr[31:2], 2'b00};
        if (e_fault)                  ph = '{P_FAULT, P_IDLE};
        else if (i_inst[14:12] == 3'd2) ph = '{P_WRITE, P_DONE, P_IDLE};
        else                          ph = '{P_READ, P_WAIT, P_WRITE, P_DONE, P_IDLE};
        @(negedge clk);
        inst = i_inst; addr = i_addr; wdata = i_wdata; req_valid = 1'b1;
        mem_rdata = $urandom;
        check({nm, " accept"}, outs(), exp_of(P_IDLE, 0, 0));
        @(posedge clk); #1;
        req_valid = 1'b0;
        inst = $urandom; addr = $urandom; wdata = $urandom;
        foreach (ph[k]) begin
            mem_rdata = (ph[k] == P_WAIT) ? i_rdata : $urandom;
            check($sformatf("%s +%0d", nm, k + 1), outs(), exp_of(ph[k], al, e_merged));
            if (k < ph.size() - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    vec_t tv[12];

    initial begin
        logic [32:0] mr;
        logic [31:0] ri, ra, rw, rr;
        int we_cnt;
        int done_k[$];
        logic [2:0] bb_exp [1:7];

        rst_n = 1'b0; req_valid = 1'b0; inst = '0; addr = '0; wdata = '0; mem_rdata = '0;
        #12;
        check("reset", outs(), exp_of(P_IDLE, 0, 0));
        @(negedge clk); rst_n = 1'b1;

        tv[0]  = '{"sw_100",   mk_inst(7'h23, 3'd2), 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 32'hDEADBEEF};
        tv[1]  = '{"sb_103",   mk_inst(7'h23, 3'd0), 32'h103, 32'h12345678, 32'hAABBCCDD, 1'b0, 32'h78BBCCDD};
        tv[2]  = '{"sh_202",   mk_inst(7'h23, 3'd1), 32'h202, 32'h0000BEEF, 32'h11223344, 1'b0, 32'hBEEF3344};
        tv[3]  = '{"sh_201",   mk_inst(7'h23, 3'd1), 32'h201, 32'h0000BEEF, 32'h11223344, 1'b1, 32'h0};
        tv[4]  = '{"sw_102",   mk_inst(7'h23, 3'd2), 32'h102, 32'h55555555, 32'h0,        1'b1, 32'h0};
        tv[5]  = '{"f3_011",   mk_inst(7'h23, 3'd3), 32'h100, 32'h55555555, 32'h0,        1'b1, 32'h0};
        tv[6]  = '{"op_load",  mk_inst(7'h03, 3'd2), 32'h100, 32'h55555555, 32'h0,        1'b1, 32'h0};
        tv[7]  = '{"sb_100",   mk_inst(7'h23, 3'd0), 32'h100, 32'hFFFFFFEE, 32'h11223344, 1'b0, 32'h112233EE};
        tv[8]  = '{"sb_101",   mk_inst(7'h23, 3'd0), 32'h101, 32'h000000EE, 32'h11223344, 1'b0, 32'h1122EE44};
        tv[9]  = '{"sb_102",   mk_inst(7'h23, 3'd0), 32'h102, 32'h000000EE, 32'h11223344, 1'b0, 32'h11EE3344};
        tv[10] = '{"sh_200",   mk_inst(7'h23, 3'd1), 32'h200, 32'hFFFFCAFE, 32'h11223344, 1'b0, 32'h1122CAFE};
        tv[11] = '{"sw_101",   mk_inst(7'h23, 3'd2), 32'h101, 32'h12345678, 32'h0,        1'b1, 32'h0};
        foreach (tv[i])
            do_store(tv[i].name, tv[i].inst, tv[i].addr, tv[i].wdata, tv[i].rdata, tv[i].fault, tv[i].merged);

        // Reset during WAIT abandons the write.
        @(negedge clk);
        inst = mk_inst(7'h23, 3'd0); addr = 32'h104; wdata = 32'hAB; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        mem_rdata = 32'h01020304;
        rst_n = 1'b0; #1;
        check("rst_mid", outs(), exp_of(P_IDLE, 0, 0));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("rst_hold%0d", k), outs(), exp_of(P_IDLE, 0, 0));
        end
        @(negedge clk); rst_n = 1'b1;
        do_store("sw_after_rst", mk_inst(7'h23, 3'd2), 32'h0, 32'h1, 32'h0, 1'b0, 32'h1);

        // Back-to-back SWs with req_valid held high; busy-time changes ignored.
        bb_exp[1] = 3'b010; bb_exp[2] = 3'b001; bb_exp[3] = 3'b100; bb_exp[4] = 3'b010;
        bb_exp[5] = 3'b001; bb_exp[6] = 3'b100; bb_exp[7] = 3'b100;
        we_cnt = 0;
        @(negedge clk);
        inst = mk_inst(7'h23, 3'd2); addr = 32'h40; wdata = 32'hAAAA0001; req_valid = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin addr = 32'h44; wdata = 32'hBBBB0002; end
            if (k == 4) req_valid = 1'b0;
            check($sformatf("b2b rdy/we/done k%0d", k), {66'h0, req_ready, mem_we, done},
                  {66'h0, bb_exp[k]});
            if (mem_we) we_cnt++;
            if (done) done_k.push_back(k);
            if (k == 1) check("b2b wr1", {5'h0, mem_addr, mem_wdata}, {5'h0, 32'h40, 32'hAAAA0001});
            if (k == 4) check("b2b wr2", {5'h0, mem_addr, mem_wdata}, {5'h0, 32'h44, 32'hBBBB0002});
        end
        check("b2b we_count", 69'(we_cnt), 69'd2);
        check("b2b done_spacing", 69'(done_k.size() == 2 ? done_k[1] - done_k[0] : -1), 69'd3);

        // Randomized transactions against the byte-array reference.
        for (int n = 0; n < 60; n++) begin
            rr = $urandom; rw = $urandom; ra = $urandom;
            ri = mk_inst(($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'h23,
                         ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1 && ri[14:12] != 3'd0) ra[1:0] = 2'b00;
            mr = model(ri, ra, rw, rr);
            do_store($sformatf("rnd%0d", n), ri, ra, rw, rr, mr[32], mr[31:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
